// File: rtl/button_debounce_pkg.sv
// Shared types and defaults for the button debounce filter.
package button_debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounce filter: out_o follows the sampled input after STABLE_CYCLES identical samples.
// BUTTON_DEBOUNCE_SYNC_EN inserts a two-flop synchroniser ahead of the state machine.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic out_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_q;

`ifdef BUTTON_DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (in_i),
        .q_o (s)
    );
`else
    assign s = in_i;
`endif

    // Qualification FSM; any opposite sample during a wait state restarts from the settled state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            case (state_q)
                LOW: begin
                    if (s) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        out_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= LOW;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_o = out_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with STABLE_CYCLES=4; latency follows BUTTON_DEBOUNCE_SYNC_EN.
module tb_button_debounce;

    localparam int unsigned STABLE = 4;
`ifdef BUTTON_DEBOUNCE_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic clk;
    logic rst;
    logic in_i;
    logic out_o;

    logic exp_q[$];
    int   n_pass;
    int   n_total;
    int   n_item;

    button_debounce #(.STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst   (rst),
        .in_i  (in_i),
        .out_o (out_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; each queued value is the out_o expected after the next rising edge.
    task automatic step(input logic r, input logic d, input logic e);
        @(negedge clk);
        rst  = r;
        in_i = d;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic got, input logic want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, got, want, $time);
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled just after the edge.
    initial begin
        n_item = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic e;
                e = exp_q.pop_front();
                n_total++;
                if (out_o === e) n_pass++;
                else $display("FAIL out item %0d: got %0b expected %0b at %0t", n_item, out_o, e, $time);
                n_item++;
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        in_i    = 1'b0;

        // Reset held with toggling input, then release with input low.
        for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

        // Clean press.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'(i >= LAT - 1));

        // Release glitch of two cycles is suppressed, then a real release.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'(!(i >= LAT - 1)));

        // Bouncing press: 3 high, 1 low, then held high.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'(i >= LAT - 1));

        // Release back to low.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'(!(i >= LAT - 1)));

        // Reset mid-count: qualification restarts from reset release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'(i >= LAT - 1));

        // Reset while high clears out_o without waiting for a clock edge.
        step(1'b1, 1'b1, 1'b0);
        #1;
        check_now("async_reset", out_o, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check_now("scoreboard_drained", 1'(exp_q.size() == 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
